rv32v_memory_stage: RTL and testbench

Vector memory stage. Consumes the execute→memory bundle (two element lanes per beat), performs unit-stride and indexed vector loads/stores over the single-port data bus one lane at a time, and presents a registered writeback beat to the vector writeback stage. Stalls execute while a beat is in flight; non-memory beats pass through with one cycle of latency.

---
 rtl/rv32i_types_pkg.sv | 80 ++++++++
 rtl/rv32v_mem_lane_align.sv | 43 ++++
 rtl/rv32v_memory_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_rv32v_memory_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32 vector core types.
// Element offset, width, SEW and CSR-config selectors plus memory-stage FSM.
package rv32i_types_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [3:0] offset_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } width_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_t;

  typedef enum logic [1:0] {
    CFG_NONE     = 2'd0,
    CFG_VSETVLI  = 2'd1,
    CFG_VSETIVLI = 2'd2,
    CFG_VSETVL   = 2'd3
  } cfgsel_t;

  typedef enum logic [1:0] {
    VMEM_IDLE  = 2'd0,
    VMEM_LANE0 = 2'd1,
    VMEM_LANE1 = 2'd2,
    VMEM_DONE  = 2'd3
  } vmem_state_t;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] sdata0;
    logic [31:0] sdata1;
    offset_t     woff0;
    offset_t     woff1;
    width_t      eew;
    logic [4:0]  vd;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic [31:0] vl;
    logic [31:0] vstart;
    logic [31:0] next_avl;
    logic [7:0]  vtype;
    logic [7:0]  next_vtype;
    cfgsel_t     cfg;
  } vmem_beat_t;

  // Reserved width encoding is handled as a word access.
  function automatic logic misaligned(width_t w, logic [1:0] a);
    logic m;
    m = 1'b0;
    unique case (w)
      WIDTH_BYTE: m = 1'b0;
      WIDTH_HALF: m = a[0];
      default:    m = |a;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] align_addr(width_t w, logic [31:0] a);
    logic [31:0] r;
    r = a;
    unique case (w)
      WIDTH_BYTE: r = a;
      WIDTH_HALF: r[0] = 1'b0;
      default:    r[1:0] = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32v_mem_lane_align.sv
// Lane alignment for one vector element access on the 32-bit data bus.
// In: width, addr[1:0], store data, raw read data. Out: byte_en, wdata, ldata.
module rv32v_mem_lane_align
  import rv32i_types_pkg::*;
(
  input  width_t      width,
  input  logic [1:0]  a,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] sh;

  always_comb begin
    byte_en = 4'b0000;
    wdata   = '0;
    ldata   = '0;
    sh      = '0;
    unique case (1'b1)
      (width == WIDTH_BYTE): begin
        byte_en = 4'b0001 << a;
        wdata   = {4{sdata[7:0]}};
        sh      = rdata >> {a, 3'b000};
        ldata   = {24'h0, sh[7:0]};
      end
      (width == WIDTH_HALF): begin
        byte_en = 4'b0011 << {a[1], 1'b0};
        wdata   = {2{sdata[15:0]}};
        sh      = rdata >> {a[1], 4'b0000};
        ldata   = {16'h0, sh[15:0]};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = sdata;
        ldata   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/rv32v_memory_stage.sv
// Vector memory stage: two-lane beats, lane-serial loads/stores on one bus.
// Ports: execute bundle in, mem_stall out, dmem_* bus, registered wb_* beat.
// Option RV32V_MEM_MISALIGN_TRAP_EN: misaligned lanes fault (misalign_fault)
// instead of being forced to alignment.
module rv32v_memory_stage
  import rv32i_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic              load_ena,
  input  logic              store_ena,
  input  logic [1:0]        wen,
  input  logic [31:0]       aluresult0,
  input  logic [31:0]       aluresult1,
  input  logic [31:0]       storedata0,
  input  logic [31:0]       storedata1,
  input  offset_t           woffset0,
  input  offset_t           woffset1,
  input  width_t            eew_loadstore,
  input  logic [4:0]        vd,
  input  logic [4:0]        rd_sel,
  input  logic [31:0]       rd_data,
  input  logic              rd_wen,
  input  logic [31:0]       vl,
  input  logic [31:0]       vstart,
  input  logic [31:0]       next_avl_csr,
  input  logic [7:0]        vtype,
  input  logic [7:0]        next_vtype_csr,
  input  cfgsel_t           config_type,
  output logic              mem_stall,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_byte_en,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_busy,
  output logic              wb_valid,
  output logic [1:0]        wb_wen,
  output logic [31:0]       wb_data0,
  output logic [31:0]       wb_data1,
  output offset_t           wb_woffset0,
  output offset_t           wb_woffset1,
  output logic [4:0]        wb_vd,
  output logic [4:0]        wb_rd_sel,
  output logic [31:0]       wb_rd_data,
  output logic              wb_rd_wen,
  output logic [31:0]       wb_vl,
  output logic [31:0]       wb_vstart,
  output logic [31:0]       wb_next_avl_csr,
  output logic [7:0]        wb_vtype,
  output logic [7:0]        wb_next_vtype_csr,
  output cfgsel_t           wb_config_type
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_fault
`endif
);

  vmem_state_t state_q, state_d;
  vmem_beat_t  beat_q, beat_d, in_beat;
  logic [1:0]  wen_q, wen_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic [1:0]  wen_eff;

  logic        in_lane;
  logic        done;
  logic [31:0] cur_addr;
  logic [31:0] cur_al;
  logic [31:0] cur_sdata;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ldata;

`ifdef RV32V_MEM_MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
  logic [1:0]  mis;

  assign mis = {misaligned(eew_loadstore, aluresult1[1:0]),
                misaligned(eew_loadstore, aluresult0[1:0])};
  // Faulting lanes are dropped at accept so they never reach the bus.
  assign wen_eff = wen & ~mis;
`else
  assign wen_eff = wen;
`endif

  always_comb begin
    in_beat            = '0;
    in_beat.ld         = load_ena;
    in_beat.st         = store_ena;
    in_beat.addr0      = aluresult0;
    in_beat.addr1      = aluresult1;
    in_beat.sdata0     = storedata0;
    in_beat.sdata1     = storedata1;
    in_beat.woff0      = woffset0;
    in_beat.woff1      = woffset1;
    in_beat.eew        = eew_loadstore;
    in_beat.vd         = vd;
    in_beat.rd_sel     = rd_sel;
    in_beat.rd_data    = rd_data;
    in_beat.rd_wen     = rd_wen;
    in_beat.vl         = vl;
    in_beat.vstart     = vstart;
    in_beat.next_avl   = next_avl_csr;
    in_beat.vtype      = vtype;
    in_beat.next_vtype = next_vtype_csr;
    in_beat.cfg        = config_type;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wen_d   = wen_q;
    data0_d = data0_q;
    data1_d = data1_q;
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      VMEM_IDLE: begin
        if (ex_valid) begin
          beat_d  = in_beat;
          data0_d = '0;
          data1_d = '0;
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
          fault_d = 1'b0;
`endif
          if (!(load_ena || store_ena)) begin
            wen_d   = wen;
            data0_d = wen[0] ? aluresult0 : '0;
            data1_d = wen[1] ? aluresult1 : '0;
            state_d = VMEM_DONE;
          end else begin
            wen_d = wen_eff;
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
            fault_d = |(wen & mis);
`endif
            if (wen_eff[0]) begin
              state_d = VMEM_LANE0;
            end else if (wen_eff[1]) begin
              state_d = VMEM_LANE1;
            end else begin
              state_d = VMEM_DONE;
            end
          end
        end
      end
      VMEM_LANE0: begin
        if (!dmem_busy) begin
          if (beat_q.ld) begin
            data0_d = lane_ldata;
          end
          state_d = wen_q[1] ? VMEM_LANE1 : VMEM_DONE;
        end
      end
      VMEM_LANE1: begin
        if (!dmem_busy) begin
          if (beat_q.ld) begin
            data1_d = lane_ldata;
          end
          state_d = VMEM_DONE;
        end
      end
      VMEM_DONE: state_d = VMEM_IDLE;
      default:   state_d = VMEM_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= VMEM_IDLE;
      beat_q  <= '0;
      wen_q   <= 2'b00;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wen_q   <= wen_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

`ifdef RV32V_MEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  assign in_lane   = (state_q == VMEM_LANE0) || (state_q == VMEM_LANE1);
  assign done      = (state_q == VMEM_DONE);
  assign cur_addr  = (state_q == VMEM_LANE1) ? beat_q.addr1 : beat_q.addr0;
  assign cur_sdata = (state_q == VMEM_LANE1) ? beat_q.sdata1 : beat_q.sdata0;

`ifdef RV32V_MEM_MISALIGN_TRAP_EN
  assign cur_al = cur_addr;
`else
  assign cur_al = align_addr(beat_q.eew, cur_addr);
`endif

  rv32v_mem_lane_align u_align (
    .width   (beat_q.eew),
    .a       (cur_al[1:0]),
    .sdata   (cur_sdata),
    .rdata   (dmem_rdata),
    .byte_en (lane_be),
    .wdata   (lane_wdata),
    .ldata   (lane_ldata)
  );

  // Load wins if both enables arrive, so ren/wen are never both high.
  assign dmem_ren     = in_lane & beat_q.ld;
  assign dmem_wen     = in_lane & beat_q.st & ~beat_q.ld;
  assign dmem_addr    = in_lane ? cur_al[ADDR_W-1:0] : '0;
  assign dmem_byte_en = in_lane ? lane_be : 4'b0000;
  assign dmem_wdata   = dmem_wen ? lane_wdata : '0;

  assign mem_stall = (state_q != VMEM_IDLE) | ex_valid;

  assign wb_valid          = done;
  assign wb_wen            = (done && !beat_q.st) ? wen_q : 2'b00;
  assign wb_data0          = done ? data0_q : '0;
  assign wb_data1          = done ? data1_q : '0;
  assign wb_woffset0       = done ? beat_q.woff0 : '0;
  assign wb_woffset1       = done ? beat_q.woff1 : '0;
  assign wb_vd             = done ? beat_q.vd : '0;
  assign wb_rd_sel         = done ? beat_q.rd_sel : '0;
  assign wb_rd_data        = done ? beat_q.rd_data : '0;
  assign wb_rd_wen         = done & beat_q.rd_wen;
  assign wb_vl             = done ? beat_q.vl : '0;
  assign wb_vstart         = done ? beat_q.vstart : '0;
  assign wb_next_avl_csr   = done ? beat_q.next_avl : '0;
  assign wb_vtype          = done ? beat_q.vtype : '0;
  assign wb_next_vtype_csr = done ? beat_q.next_vtype : '0;
  assign wb_config_type    = done ? beat_q.cfg : CFG_NONE;

`ifdef RV32V_MEM_MISALIGN_TRAP_EN
  assign misalign_fault = done & fault_q;
`endif

endmodule

// File: tb/tb_rv32v_memory_stage.sv
// Self-checking bench for rv32v_memory_stage.
// Random and directed beats against a transaction-level reference model.
module tb_rv32v_memory_stage;
  import rv32i_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, load_ena, store_ena;
  logic [1:0]  wen;
  logic [31:0] aluresult0, aluresult1, storedata0, storedata1;
  offset_t     woffset0, woffset1;
  width_t      eew_loadstore;
  logic [4:0]  vd, rd_sel;
  logic [31:0] rd_data;
  logic        rd_wen;
  logic [31:0] vl, vstart, next_avl_csr;
  logic [7:0]  vtype, next_vtype_csr;
  cfgsel_t     config_type;
  logic        mem_stall, dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_busy;
  logic        wb_valid;
  logic [1:0]  wb_wen;
  logic [31:0] wb_data0, wb_data1;
  offset_t     wb_woffset0, wb_woffset1;
  logic [4:0]  wb_vd, wb_rd_sel;
  logic [31:0] wb_rd_data;
  logic        wb_rd_wen;
  logic [31:0] wb_vl, wb_vstart, wb_next_avl_csr;
  logic [7:0]  wb_vtype, wb_next_vtype_csr;
  cfgsel_t     wb_config_type;
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  rv32v_memory_stage #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .load_ena(load_ena), .store_ena(store_ena),
    .wen(wen), .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1),
    .woffset0(woffset0), .woffset1(woffset1),
    .eew_loadstore(eew_loadstore), .vd(vd), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_wen(rd_wen), .vl(vl), .vstart(vstart),
    .next_avl_csr(next_avl_csr), .vtype(vtype),
    .next_vtype_csr(next_vtype_csr), .config_type(config_type),
    .mem_stall(mem_stall), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_byte_en(dmem_byte_en), .dmem_rdata(dmem_rdata),
    .dmem_busy(dmem_busy), .wb_valid(wb_valid), .wb_wen(wb_wen),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .wb_woffset0(wb_woffset0), .wb_woffset1(wb_woffset1),
    .wb_vd(wb_vd), .wb_rd_sel(wb_rd_sel), .wb_rd_data(wb_rd_data),
    .wb_rd_wen(wb_rd_wen), .wb_vl(wb_vl), .wb_vstart(wb_vstart),
    .wb_next_avl_csr(wb_next_avl_csr), .wb_vtype(wb_vtype),
    .wb_next_vtype_csr(wb_next_vtype_csr),
    .wb_config_type(wb_config_type)
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
    ,
    .misalign_fault(misalign_fault)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] be_of(int unsigned off, int unsigned size);
    logic [3:0] be;
    be = 4'b0000;
    for (int unsigned i = 0; i < 4; i++)
      if (i >= off && i < off + size) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] wd_of(logic [31:0] sd, int unsigned size);
    logic [31:0] wd;
    wd = '0;
    for (int unsigned i = 0; i < 4; i++)
      wd[8*i +: 8] = sd[8*(i % size) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] ld_of(logic [31:0] r, int unsigned off,
                                        int unsigned size);
    logic [31:0] v;
    v = r >> (8 * off);
    if (size < 4) v = v & ((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; load_ena = 1'b0; store_ena = 1'b0; wen = 2'b00;
  endtask

  // Execute is stalled, so whatever it shows must be ignored.
  task automatic scramble();
    ex_valid   = 1'($urandom_range(0, 1));
    load_ena   = 1'($urandom_range(0, 1));
    store_ena  = 1'($urandom_range(0, 1));
    wen        = 2'($urandom_range(0, 3));
    aluresult0 = $urandom; aluresult1 = $urandom;
    storedata0 = $urandom; storedata1 = $urandom;
    eew_loadstore = width_t'($urandom_range(0, 2));
    vd = 5'($urandom); rd_data = $urandom; vl = $urandom;
  endtask

  task automatic run_beat(input bit ld, input bit st, input logic [1:0] w,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] s0, input logic [31:0] s1,
                          input logic [1:0] ew, input int b0, input int b1,
                          input logic [31:0] r0, input logic [31:0] r1);
    logic [31:0] a[2];
    logic [31:0] s[2];
    logic [31:0] r[2];
    int          bz[2];
    logic [31:0] exp_d[2];
    logic [1:0]  eff, exp_wen;
    bit          flt, done;
    int unsigned size, off;
    int          lat, cyc, left;
    logic [31:0] q_addr[$], q_wd[$], q_rd[$];
    logic [3:0]  q_be[$];
    int          q_bz[$];
    logic [4:0]  t_vd, t_rs;
    logic [31:0] t_rdd, t_vl, t_vs, t_avl;
    logic [7:0]  t_vt, t_nvt;
    logic        t_rw;
    offset_t     t_wo0, t_wo1;
    cfgsel_t     t_cfg;

    a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1;
    r[0] = r0; r[1] = r1; bz[0] = b0; bz[1] = b1;
    size = (ew == 2'd0) ? 1 : (ew == 2'd1) ? 2 : 4;
    eff = w; flt = 1'b0; lat = 2;
    for (int i = 0; i < 2; i++) begin
      exp_d[i] = '0;
      if (ld || st) begin
        if (a[i] % size != 0) begin
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
          if (w[i]) flt = 1'b1;
          eff[i] = 1'b0;
`else
          a[i] = a[i] - (a[i] % size);
`endif
        end
        if (eff[i]) begin
          off = a[i] % 4;
          q_addr.push_back(a[i]);
          q_be.push_back(be_of(off, size));
          q_wd.push_back(wd_of(s[i], size));
          q_rd.push_back(r[i]);
          q_bz.push_back(bz[i]);
          lat += bz[i] + 1;
          if (ld) exp_d[i] = ld_of(r[i], off, size);
        end
      end else if (w[i]) begin
        exp_d[i] = a[i];
      end
    end
    exp_wen = st ? 2'b00 : eff;

    t_vd = 5'($urandom); t_rs = 5'($urandom); t_rdd = $urandom;
    t_rw = 1'($urandom); t_vl = $urandom; t_vs = $urandom;
    t_avl = $urandom; t_vt = 8'($urandom); t_nvt = 8'($urandom);
    t_wo0 = offset_t'($urandom); t_wo1 = offset_t'($urandom);
    t_cfg = cfgsel_t'($urandom_range(0, 3));

    ex_valid = 1'b1; load_ena = ld; store_ena = st; wen = w;
    aluresult0 = a0; aluresult1 = a1; storedata0 = s0; storedata1 = s1;
    eew_loadstore = width_t'(ew);
    woffset0 = t_wo0; woffset1 = t_wo1; vd = t_vd; rd_sel = t_rs;
    rd_data = t_rdd; rd_wen = t_rw; vl = t_vl; vstart = t_vs;
    next_avl_csr = t_avl; vtype = t_vt; next_vtype_csr = t_nvt;
    config_type = t_cfg;
    dmem_busy = 1'b0;
    #1;
    check("stall_accept", mem_stall, 1);

    cyc = 1; done = 1'b0;
    left = (q_bz.size() > 0) ? q_bz[0] : 0;
    while (!done && cyc < 40) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      scramble();
      dmem_busy = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_ren || dmem_wen) begin
        if (q_addr.size() == 0) begin
          check("req_spurious", {dmem_ren, dmem_wen}, 0);
        end else begin
          check("req_kind", {dmem_ren, dmem_wen}, {ld, st});
          check("req_addr", dmem_addr, q_addr[0]);
          check("req_be", dmem_byte_en, q_be[0]);
          if (st) check("req_wdata", dmem_wdata, q_wd[0]);
          if (left > 0) begin
            dmem_busy = 1'b1;
            left--;
          end else begin
            dmem_rdata = q_rd[0];
            void'(q_addr.pop_front()); void'(q_be.pop_front());
            void'(q_wd.pop_front()); void'(q_rd.pop_front());
            void'(q_bz.pop_front());
            left = (q_bz.size() > 0) ? q_bz[0] : 0;
          end
        end
      end
      if (wb_valid) begin
        done = 1'b1;
        check("wb_latency", cyc, lat);
        check("req_left", q_addr.size(), 0);
        check("done_bus", {dmem_ren, dmem_wen}, 0);
        check("wb_wen", wb_wen, exp_wen);
        check("wb_data0", wb_data0, exp_d[0]);
        check("wb_data1", wb_data1, exp_d[1]);
        check("wb_scalar", {wb_vd, wb_rd_sel, wb_rd_wen, wb_rd_data},
              {t_vd, t_rs, t_rw, t_rdd});
        check("wb_csr0", {wb_vl, wb_vstart}, {t_vl, t_vs});
        check("wb_csr1", {wb_next_avl_csr, wb_vtype, wb_next_vtype_csr,
              wb_config_type, wb_woffset0, wb_woffset1},
              {t_avl, t_vt, t_nvt, t_cfg, t_wo0, t_wo1});
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
        check("wb_fault", misalign_fault, flt);
`endif
      end
    end
    if (!done) check("wb_timeout", 0, 1);
    idle_inputs();
    @(negedge CLK);
    check("idle_stall", mem_stall, 0);
    check("idle_valid", wb_valid, 0);
  endtask

  initial begin
    int kind;
    RST = 1'b1;
    idle_inputs();
    aluresult0 = '0; aluresult1 = '0; storedata0 = '0; storedata1 = '0;
    woffset0 = '0; woffset1 = '0; eew_loadstore = WIDTH_WORD;
    vd = '0; rd_sel = '0; rd_data = '0; rd_wen = 1'b0;
    vl = '0; vstart = '0; next_avl_csr = '0; vtype = '0;
    next_vtype_csr = '0; config_type = CFG_NONE;
    dmem_rdata = '0; dmem_busy = 1'b0;
    #1;
    check("rst_bus", {dmem_ren, dmem_wen, dmem_byte_en, dmem_addr}, 0);
    check("rst_wb", {wb_valid, wb_wen, wb_data0, wb_rd_wen}, 0);
    check("rst_stall", mem_stall, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    run_beat(0, 0, 2'b11, 32'h11, 32'h22, 0, 0, 2'd2, 0, 0, 0, 0);
    run_beat(1, 0, 2'b11, 32'h100, 32'h104, 0, 0, 2'd2, 0, 0,
             32'hAAAA5555, 32'h12345678);
    run_beat(0, 1, 2'b10, 32'h0, 32'h203, 0, 32'h7F, 2'd0, 0, 0, 0, 0);
    run_beat(1, 0, 2'b01, 32'h102, 32'h0, 0, 0, 2'd1, 3, 0,
             32'hBEEF0000, 0);
`ifdef RV32V_MEM_MISALIGN_TRAP_EN
    run_beat(1, 0, 2'b01, 32'h101, 32'h0, 0, 0, 2'd2, 0, 0, $urandom, 0);
`endif

    // Reset while lane 1 waits on a busy bus.
    ex_valid = 1'b1; load_ena = 1'b1; store_ena = 1'b0; wen = 2'b11;
    aluresult0 = 32'h300; aluresult1 = 32'h304;
    eew_loadstore = WIDTH_WORD; dmem_busy = 1'b0;
    @(posedge CLK);
    #1 idle_inputs();
    @(posedge CLK);
    #1 dmem_busy = 1'b1;
    check("rst_pre_lane1", {dmem_ren, dmem_addr}, {1'b1, 32'h304});
    #2 RST = 1'b1;
    #1;
    check("rst_mid_ren", dmem_ren, 0);
    check("rst_mid_wb", {wb_valid, mem_stall}, 0);
    repeat (2) begin
      @(negedge CLK);
      check("rst_hold_wb", wb_valid, 0);
    end
    RST = 1'b0;
    dmem_busy = 1'b0;
    @(negedge CLK);
    run_beat(1, 0, 2'b11, 32'h400, 32'h404, 0, 0, 2'd2, 1, 0,
             32'h0BAD_F00D, 32'hCAFE_0001);

    repeat (150) begin
      kind = $urandom_range(0, 2);
      run_beat(kind == 1, kind == 2, 2'($urandom_range(0, 3)),
               $urandom & 32'hFFFF, $urandom & 32'hFFFF,
               $urandom, $urandom, 2'($urandom_range(0, 2)),
               $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
